// File: rtl/board_port_arbiter.sv
// Arbitrates the shared board-memory port between the game FSM (G), the victory checker (C)
// and the display scanner (D), and returns read data tagged to the requester that issued it.
module board_port_arbiter #(
  parameter int ROW_BITS     = 3,
  parameter int COL_BITS     = 3,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                g_req,
  input  logic [ROW_BITS-1:0] g_row,
  input  logic [COL_BITS-1:0] g_col,
  input  logic                g_write,
  input  logic [1:0]          g_wdata,
  output logic                g_gnt,
  output logic                g_rvalid,
  input  logic                c_req,
  input  logic [ROW_BITS-1:0] c_row,
  input  logic [COL_BITS-1:0] c_col,
  output logic                c_gnt,
  output logic                c_rvalid,
  input  logic                d_req,
  input  logic [ROW_BITS-1:0] d_row,
  input  logic [COL_BITS-1:0] d_col,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [ROW_BITS-1:0] mem_row,
  output logic [COL_BITS-1:0] mem_col,
  output logic                mem_write,
  output logic [1:0]          mem_wdata,
  input  logic [1:0]          mem_rdata,
  output logic [1:0]          rdata,
  output logic                d_promoted
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_G    = 2'd1,
    TAG_C    = 2'd2,
    TAG_D    = 2'd3
  } tag_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  tag_t                tag_pipe [READ_LATENCY];
  tag_t                push_tag;
  tag_t                ret_tag;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [7:0]          starve_cnt;
  logic [7:0]          starve_nxt;
  logic                promoted_q;

  // Grants are suppressed while reset is held so nothing reaches the memory port.
  always_comb begin
    g_gnt = 1'b0;
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (!promoted_q) begin
        if (g_req)      g_gnt = 1'b1;
        else if (c_req) c_gnt = 1'b1;
        else if (d_req) d_gnt = 1'b1;
      end else begin
        if (g_req && g_write)       g_gnt = 1'b1;
        else if (d_req)             d_gnt = 1'b1;
        else if (g_req && !g_write) g_gnt = 1'b1;
        else if (c_req)             c_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_row   = row_q;
    mem_col   = col_q;
    mem_write = g_gnt & g_write;
    mem_wdata = g_gnt ? g_wdata : 2'b00;
    push_tag  = TAG_NONE;
    if (g_gnt) begin
      mem_row  = g_row;
      mem_col  = g_col;
      push_tag = g_write ? TAG_NONE : TAG_G;
    end else if (c_gnt) begin
      mem_row  = c_row;
      mem_col  = c_col;
      push_tag = TAG_C;
    end else if (d_gnt) begin
      mem_row  = d_row;
      mem_col  = d_col;
      push_tag = TAG_D;
    end
  end

  // Address shadow keeps the port stable on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (g_gnt || c_gnt || d_gnt) begin
      row_q <= mem_row;
      col_q <= mem_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= push_tag;
      for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_comb begin
    ret_tag  = tag_pipe[READ_LATENCY-1];
    g_rvalid = (ret_tag == TAG_G);
    c_rvalid = (ret_tag == TAG_C);
    d_rvalid = (ret_tag == TAG_D);
    rdata    = mem_rdata;
  end

  // Promotion is computed from the next count so D wins on the cycle after the limit-th denial.
  always_comb begin
    starve_nxt = 8'd0;
    if (d_req && !d_gnt) begin
      starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'd0;
      promoted_q <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      promoted_q <= (starve_nxt == LIMIT);
    end
  end

  assign d_promoted = promoted_q;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Scoreboard bench for board_port_arbiter: two instances (read latency 1 and 3) share stimulus,
// each backed by a small board-memory model; a monitor matches returned reads against expectations.
module tb_board_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       g_req, c_req, d_req, g_write;
  logic [2:0] g_row, g_col, c_row, c_col, d_row, d_col;
  logic [1:0] g_wdata;

  logic       g_gnt1, g_rvalid1, c_gnt1, c_rvalid1, d_gnt1, d_rvalid1, mem_write1, d_promoted1;
  logic [2:0] mem_row1, mem_col1;
  logic [1:0] mem_wdata1, mem_rdata1, rdata1;
  logic       g_gnt3, g_rvalid3, c_gnt3, c_rvalid3, d_gnt3, d_rvalid3, mem_write3, d_promoted3;
  logic [2:0] mem_row3, mem_col3;
  logic [1:0] mem_wdata3, mem_rdata3, rdata3;

  board_port_arbiter #(.ROW_BITS(3), .COL_BITS(3), .READ_LATENCY(1), .STARVE_LIMIT(15)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .g_req(g_req), .g_row(g_row), .g_col(g_col), .g_write(g_write), .g_wdata(g_wdata),
    .g_gnt(g_gnt1), .g_rvalid(g_rvalid1),
    .c_req(c_req), .c_row(c_row), .c_col(c_col), .c_gnt(c_gnt1), .c_rvalid(c_rvalid1),
    .d_req(d_req), .d_row(d_row), .d_col(d_col), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1),
    .mem_row(mem_row1), .mem_col(mem_col1), .mem_write(mem_write1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .rdata(rdata1), .d_promoted(d_promoted1)
  );

  board_port_arbiter #(.ROW_BITS(3), .COL_BITS(3), .READ_LATENCY(3), .STARVE_LIMIT(15)) u_l3 (
    .clk(clk), .rst_n(rst_n),
    .g_req(g_req), .g_row(g_row), .g_col(g_col), .g_write(g_write), .g_wdata(g_wdata),
    .g_gnt(g_gnt3), .g_rvalid(g_rvalid3),
    .c_req(c_req), .c_row(c_row), .c_col(c_col), .c_gnt(c_gnt3), .c_rvalid(c_rvalid3),
    .d_req(d_req), .d_row(d_row), .d_col(d_col), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
    .mem_row(mem_row3), .mem_col(mem_col3), .mem_write(mem_write3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .rdata(rdata3), .d_promoted(d_promoted3)
  );

  function automatic logic [1:0] pat(input int k);
    return 2'((k / 8) * 3 + (k % 8));
  endfunction

  // Board memory model: the address is delayed by the read latency of each instance.
  logic [1:0] board [64];
  logic       mem_init;
  logic [5:0] a1;
  logic [5:0] a3 [3];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) board[k] <= pat(k);
    end else if (mem_write1) begin
      board[{mem_row1, mem_col1}] <= mem_wdata1;
    end
    a1    <= {mem_row1, mem_col1};
    a3[0] <= {mem_row3, mem_col3};
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign mem_rdata1 = board[a1];
  assign mem_rdata3 = board[a3[2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         inst;
    int         owner;
    logic [1:0] data;
    int         due;
  } exp_t;

  exp_t       sb [$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_board [64];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sample(input logic [2:0] eg, input string nm);
    exp_t       e;
    int         owner;
    logic [5:0] a;
    @(negedge clk);
    chk({nm, " gnt L1"}, int'({g_gnt1, c_gnt1, d_gnt1}), int'(eg));
    chk({nm, " gnt L3"}, int'({g_gnt3, c_gnt3, d_gnt3}), int'(eg));
    owner = 0;
    a = '0;
    if (eg == 3'b100 && !g_write) begin owner = 1; a = {g_row, g_col}; end
    else if (eg == 3'b010)        begin owner = 2; a = {c_row, c_col}; end
    else if (eg == 3'b001)        begin owner = 3; a = {d_row, d_col}; end
    if (owner != 0) begin
      e.owner = owner;
      e.data  = exp_board[a];
      e.inst  = 1;
      e.due   = cyc + 1;
      sb.push_back(e);
      e.inst  = 3;
      e.due   = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int inst, input logic [2:0] rv, input logic [1:0] rd);
    int idx;
    int owner;
    int pend;
    idx  = -1;
    pend = 0;
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].inst == inst) begin
        if (idx < 0) idx = k;
        pend++;
      end
    end
    if (rv != 3'b000) begin
      chk($sformatf("L%0d rvalid onehot", inst), $countones(rv), 1);
      chk($sformatf("L%0d rvalid expected", inst), int'(pend > 0), 1);
      if (idx >= 0) begin
        owner = (rv == 3'b100) ? 1 : (rv == 3'b010) ? 2 : 3;
        chk($sformatf("L%0d rvalid owner", inst), owner, sb[idx].owner);
        chk($sformatf("L%0d rdata", inst), int'(rd), int'(sb[idx].data));
        chk($sformatf("L%0d rvalid cycle", inst), cyc, sb[idx].due);
        sb.delete(idx);
      end
    end else if (idx >= 0 && sb[idx].due <= cyc) begin
      chk($sformatf("L%0d rvalid present at due cycle", inst), int'(rv != 3'b000), 1);
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    mon(1, {g_rvalid1, c_rvalid1, d_rvalid1}, rdata1);
    mon(3, {g_rvalid3, c_rvalid3, d_rvalid3}, rdata3);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] eg;
    rst_n = 1'b0; mem_init = 1'b1;
    g_req = 1'b1; c_req = 1'b1; d_req = 1'b1;
    g_write = 1'b0; g_wdata = 2'b00;
    g_row = 3'd1; g_col = 3'd2; c_row = 3'd4; c_col = 3'd4; d_row = 3'd6; d_col = 3'd1;
    for (int k = 0; k < 64; k++) exp_board[k] = pat(k);

    @(negedge clk);
    chk("reset gnt", int'({g_gnt1, c_gnt1, d_gnt1, g_gnt3, c_gnt3, d_gnt3}), 0);
    chk("reset rvalid", int'({g_rvalid1, c_rvalid1, d_rvalid1, g_rvalid3, c_rvalid3, d_rvalid3}), 0);
    chk("reset mem_write", int'({mem_write1, mem_write3}), 0);
    chk("reset mem addr", int'({mem_row1, mem_col1, mem_row3, mem_col3}), 0);
    chk("reset d_promoted", int'({d_promoted1, d_promoted3}), 0);
    tick();
    mem_init = 1'b0;
    rst_n = 1'b1;

    sample(3'b100, "post-reset G"); tick();
    g_req = 1'b0;
    sample(3'b010, "C after G drop"); tick();
    c_req = 1'b0;
    sample(3'b001, "D alone"); tick();

    g_req = 1'b1; g_write = 1'b1; g_row = 3'd3; g_col = 3'd5; g_wdata = 2'b01;
    c_req = 1'b1; d_req = 1'b1;
    sample(3'b100, "G write");
    chk("write strobe", int'(mem_write1), 1);
    chk("write addr", int'({mem_row1, mem_col1}), 29);
    chk("write data", int'(mem_wdata1), 1);
    tick();
    exp_board[29] = 2'b01;
    g_write = 1'b0; c_req = 1'b0; d_req = 1'b0;
    sample(3'b100, "G read after write");
    chk("read strobe", int'(mem_write1), 0);
    tick();
    g_req = 1'b0;
    sample(3'b000, "idle");
    chk("idle addr hold", int'({mem_row1, mem_col1}), 29);
    chk("idle wdata", int'(mem_wdata1), 0);
    chk("idle write", int'(mem_write1), 0);
    tick();

    c_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_row = 3'd0; c_col = 3'(i);
      sample(3'b010, "C burst"); tick();
    end
    c_req = 1'b0;
    sample(3'b000, "burst drain"); tick();

    c_req = 1'b1; d_req = 1'b1; d_row = 3'd7; d_col = 3'd7;
    for (int i = 0; i < 32; i++) begin
      c_row = 3'(i); c_col = 3'(i + 2);
      eg = (i % 16 == 15) ? 3'b001 : 3'b010;
      sample(eg, "starve");
      chk("starve d_promoted", int'(d_promoted1), int'(i % 16 == 15));
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    sample(3'b000, "starve drain"); tick();

    c_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 19; i++) begin
      g_req = (i == 15 || i == 16 || i == 17);
      g_write = (i == 15);
      g_row = 3'd2; g_col = 3'd2; g_wdata = 2'b11;
      eg = (i == 15) ? 3'b100 : (i == 16) ? 3'b001 : (i == 17) ? 3'b100 : 3'b010;
      sample(eg, "promotion collision");
      chk("collision d_promoted", int'(d_promoted3), int'(i == 15 || i == 16));
      if (i == 15) begin
        chk("collision write strobe", int'(mem_write1), 1);
        exp_board[18] = 2'b11;
      end
      tick();
    end
    g_req = 1'b0; c_req = 1'b0; d_req = 1'b0; g_write = 1'b0;
    sample(3'b000, "collision drain"); tick();

    g_req = 1'b1; g_row = 3'd4; g_col = 3'd0;
    c_req = 1'b1; c_row = 3'd5; c_col = 3'd6;
    d_req = 1'b1; d_row = 3'd1; d_col = 3'd3;
    sample(3'b100, "pre-reset G"); tick();
    g_req = 1'b0;
    sample(3'b010, "pre-reset C"); tick();
    rst_n = 1'b0;
    sb.delete();
    g_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample(3'b000, "in reset");
      chk("in reset rvalid", int'({g_rvalid1, c_rvalid1, d_rvalid1, g_rvalid3, c_rvalid3, d_rvalid3}), 0);
      tick();
    end
    rst_n = 1'b1;
    g_req = 1'b1; c_req = 1'b0; d_req = 1'b0; g_row = 3'd6; g_col = 3'd6;
    sample(3'b100, "fresh G"); tick();
    g_req = 1'b0; c_req = 1'b1; c_row = 3'd0; c_col = 3'd7;
    sample(3'b010, "fresh C"); tick();
    c_req = 1'b0; d_req = 1'b1; d_row = 3'd7; d_col = 3'd0;
    sample(3'b001, "fresh D"); tick();
    d_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample(3'b000, "final drain"); tick();
    end
    chk("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_port_arbiter.md
Name: board_port_arbiter

Overview:
- Shares the single board-memory port between three requesters: the game FSM (G: piece writes and row lookups), the victory checker (C: neighbour reads) and the display scanner (D: refresh reads).
- Grants one requester per cycle and drives the memory port combinationally from the winner.
- Tracks outstanding reads through a latency pipeline and returns read data tagged to the owner.
- Includes an anti-starvation counter so display refresh always progresses during long victory scans.

Parameters:
ROW_BITS, 3, row address width
COL_BITS, 3, column address width
READ_LATENCY, 1, cycles from grant to valid mem_rdata (1..3)
STARVE_LIMIT, 15, consecutive denied D cycles before D is promoted (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
g_req  in  1  game FSM request
g_row  in  ROW_BITS  game row address
g_col  in  COL_BITS  game column address
g_write  in  1  1 = write g_wdata, 0 = read
g_wdata  in  2  player ID to write
g_gnt  out  1  game granted this cycle
g_rvalid  out  1  read data for G valid on rdata
c_req  in  1  checker read request
c_row  in  ROW_BITS  checker row
c_col  in  COL_BITS  checker column
c_gnt  out  1  checker granted
c_rvalid  out  1  read data for C valid
d_req  in  1  display read request
d_row  in  ROW_BITS  display row
d_col  in  COL_BITS  display column
d_gnt  out  1  display granted
d_rvalid  out  1  read data for D valid
mem_row  out  ROW_BITS  board row address
mem_col  out  COL_BITS  board column address
mem_write  out  1  board write strobe
mem_wdata  out  2  board write data
mem_rdata  in  2  board read data, valid READ_LATENCY cycles after address
rdata  out  2  shared read-return data (= mem_rdata)
d_promoted  out  1  starvation promotion active (debug)

Behaviour:
- Reset: all gnt, rvalid and mem_write = 0; mem_row/mem_col = 0; latency pipeline cleared; starve counter = 0; d_promoted = 0. A reset mid-read discards the outstanding return; no rvalid is ever asserted for a pre-reset grant.
- Grant logic is combinational from the req inputs and registered state; at most one gnt is high per cycle.
  - Normal priority: G > C > D.
  - Promoted priority (d_promoted=1): G write > D > G read > C.
  - No request: no gnt, mem_write=0, mem_row/mem_col hold their last granted values (registered shadow).
- Memory port: mem_row/mem_col follow the winner's address in the grant cycle. mem_write = g_gnt & g_write. mem_wdata = g_wdata when G is granted, else 0.
- Read tracking: each grant of a read pushes a 2-bit owner tag (none/G/C/D) into a READ_LATENCY-deep shift register. A write or an idle cycle pushes "none".
  - The tag at the pipeline output asserts exactly one x_rvalid for one cycle.
  - rdata = mem_rdata, passed through without a register.
  - Back-to-back grants give back-to-back rvalids in grant order.
- Starve counter (8-bit, saturating at STARVE_LIMIT):
  - Increments each cycle d_req=1 and d_gnt=0.
  - Clears on d_gnt or d_req=0.
  - d_promoted is registered, = (counter == STARVE_LIMIT), and drops the cycle after D is granted.
- Requesters may hold req high across cycles; each gnt cycle is one access. A requester changing its address while not granted is legal.
- Dropping req while ungranted is legal; dropping it after a grant does not cancel that grant's rvalid.
- A G write followed next cycle by a G read of the same cell returns the new data. Ordering is guaranteed by the memory, not by this block.

Test Plan:
- Reset with all reqs=1 → all gnt/rvalid=0. Release reset → cycle 0: g_gnt=1 only; when g_req drops, c_gnt=1.
- G write (row 3, col 5, wdata=2'b01) with C and D requesting → mem_write=1, mem_row=3, mem_col=5, mem_wdata=01, g_gnt=1. No g_rvalid follows.
- C reads 4 consecutive cells, READ_LATENCY=1 → c_rvalid high cycles 1..4. rdata matches the memory model for each address in order.
- c_req held continuously, d_req=1, STARVE_LIMIT=15 → d_promoted=1 after 15 denied cycles. d_gnt=1 on the 16th, then c_gnt resumes. The counter repeats the same period.
- Same as above with a G write asserted in the promotion cycle → G wins; D is granted the following cycle.
- READ_LATENCY=3, interleave G, C, D reads, then assert rst_n=0 after two grants → no rvalid after reset. After release, fresh reads return with 3-cycle latency.
